soi_probe: RTL and testbench
============================

# soi_probe

Signal-of-interest change recorder. It watches a `WIDTH`-bit signal and logs every value change into a FIFO, with optional cycle timestamps. A host-side reader drains the FIFO over a valid/ready port, normally from a DPI-C polling task. It is the hardware-initiated counterpart to host-driven signal set/get: the hardware produces the samples and the host consumes them.

## Interface
Parameters:
- `WIDTH`, 1: width of the observed signal.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TS_W`, 32: timestamp/cycle-counter width.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `soi_in`  in  WIDTH: observed signal, synchronous to `clk`.
- `arm`  in  1: capture enable, level-sensitive.
- `rd_valid`  out  1: FIFO head entry available.
- `rd_ready`  in  1: reader accepts the head entry.
- `rd_data`  out  WIDTH: head entry's sampled value.
- `rd_ts`  out  TS_W: head entry's timestamp.
- `rd_ovf`  out  1: one or more changes were dropped immediately before this entry.
- `level`  out  $clog2(DEPTH)+1: current entry count.
- `drop_cnt`  out  16: dropped-change count; saturates at 0xFFFF.

## Operation
- FSM states:
  - IDLE: no capture.
  - SEED: one cycle; unconditionally pushes the current `soi_in` as a baseline entry.
  - WATCH: pushes an entry whenever `soi_in` differs from `prev`.
- FSM transitions:
  - IDLE→SEED when `arm`=1.
  - SEED→WATCH unconditionally if `arm` is still 1, else SEED→IDLE.
  - WATCH→IDLE when `arm`=0.
- While `arm`=0 in WATCH, nothing is pushed.
- `prev` register: loads `soi_in` every cycle in all states.
- Cycle counter `cyc`:
  - Free-running, TS_W bits.
  - Increments every cycle regardless of state.
  - Wraps from 2^TS_W−1 to 0 with no flag.
- Push request (SEED, or WATCH with change) when the FIFO is not full: writes {`soi_in`, `cyc`, `pend_ovf`} and clears `pend_ovf`.
- Push request when the FIFO is full and there is no pop this cycle:
  - The entry is dropped.
  - `pend_ovf` is set.
  - `drop_cnt` increments, saturating.
- Full FIFO with push and pop in the same cycle: the push is accepted and `level` is unchanged.
- Pop occurs when `rd_valid && rd_ready`. `rd_ready` while `rd_valid`=0 is ignored.
- `rd_valid` = (`level` != 0).
- `rd_data`, `rd_ts` and `rd_ovf` show the head entry (show-ahead). All three are forced to 0 while `rd_valid`=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `level` is tracked separately.
- `drop_cnt` clears only on reset. `pend_ovf` survives arm/disarm; it is cleared only by the next successful push or by reset.

## Timing
- Reset values:
  - FSM=IDLE.
  - `prev`, `cyc`, pointers, `level`, `pend_ovf` = 0.
  - `drop_cnt`=0.
  - Outputs: `rd_valid`=0; `rd_data`, `rd_ts`, `rd_ovf` = 0.
- Reset mid-operation: all stored entries are discarded immediately (asynchronously).
- Change latency: `soi_in` differs from `prev` at edge k → entry is written at edge k → `rd_valid`=1 after edge k. `rd_ts` = value of `cyc` before edge k.
- `arm` rising: `arm` sampled 1 at edge k moves to SEED. The baseline entry is written at edge k+1. Changes are detected from edge k+2 onward.
- Pop at edge k: the next entry (or `rd_valid`=0) is visible after edge k.
- An entry pushed into an empty FIFO at edge k can be popped at edge k+1. There is no same-cycle bypass.
- `level` updates at the same edge as the push/pop.

## Configuration
- Macro: `SOI_PROBE_TIMESTAMP_EN`.
- Defined:
  - `cyc` exists.
  - Entries store TS_W timestamp bits.
  - `rd_ts` carries the timestamp.
- Undefined:
  - No counter and no timestamp storage.
  - `rd_ts` is tied to 0.
  - All other behaviour is identical, including latency and overflow.

## Test plan
- **Reset/idle:** `rst_n` low 3 cycles, `arm`=0, toggle `soi_in` → `rd_valid`=0, `level`=0, `drop_cnt`=0 throughout.
- **Seed + changes:** WIDTH=1, reset released at cycle 0; `arm`=1 sampled at edge 5 with `soi_in`=1; `soi_in`→0 for edge 10; read with `rd_ready`=1 → entries {1, ts=5, ovf=0} and {0, ts=9, ovf=0}. With the macro undefined: same data, ts=0.
- **Overflow:** DEPTH=4, `rd_ready`=0, soi toggling every cycle for 8 changes after seed → `level`=4, `drop_cnt`=5. Drain, then next change → that entry has `rd_ovf`=1 and the following entry has `rd_ovf`=0.
- **Full push+pop:** DEPTH=4 full, `rd_ready`=1 and a change in the same cycle → `level` stays 4, `drop_cnt` unchanged, new entry appears at the tail.
- **Timestamp wrap:** TS_W=4, change at cyc=15 and next at cyc=0 → `rd_ts` values 15 then 0; no other effect.
- **Reset mid-stream:** 3 entries queued, `rst_n` pulsed low mid-cycle → `rd_valid` drops asynchronously, `level`=0; after release, `arm` held 1 → new seed entry only.

Source files
------------

// File: rtl/soi_probe.sv
// soi_probe: signal-of-interest change recorder.
// Watches soi_in and queues every value change (plus a baseline sample taken
// when capture is armed) into a show-ahead FIFO drained over valid/ready.
// Optional feature macro: SOI_PROBE_TIMESTAMP_EN -- when defined, a free-running
// cycle counter timestamps every entry; when undefined, rd_ts is tied to 0.
module soi_probe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int TS_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         soi_in,
  input  logic                     arm,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic                     rd_ovf,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEED, WATCH} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pend_ovf;
  logic             push_req, push, pop, drop, full;

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             mem_ovf  [DEPTH];

`ifdef SOI_PROBE_TIMESTAMP_EN
  logic [TS_W-1:0]  cyc;
  logic [TS_W-1:0]  mem_ts   [DEPTH];
`endif

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  // NOTE: default assignment first so no path leaves state_nxt unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm) state_nxt = SEED;
      SEED:    state_nxt = arm ? WATCH : IDLE;
      WATCH:   if (!arm) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: baseline push in SEED, change-triggered push while armed in WATCH.
  always_comb begin
    push_req = 1'b0;
    case (state)
      SEED:    push_req = 1'b1;
      WATCH:   push_req = arm && (soi_in != prev);
      default: push_req = 1'b0;
    endcase
  end

  assign rd_valid = (level != '0);
  assign pop      = rd_valid && rd_ready;
  assign full     = (level == LW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Previous-sample register for change detection; loads in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= soi_in;
  end

`ifdef SOI_PROBE_TIMESTAMP_EN
  // Free-running cycle counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + TS_W'(1);
  end
`endif

  // Pointer, occupancy, overflow-pending and drop-counter bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      pend_ovf <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push)      pend_ovf <= 1'b0;
      else if (drop) pend_ovf <= 1'b1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Entry storage write port.
  // NOTE: storage is deliberately not reset; stale contents are unreachable
  // because level/pointers reset and the read outputs are gated by rd_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= soi_in;
      mem_ovf[wr_ptr]  <= pend_ovf;
`ifdef SOI_PROBE_TIMESTAMP_EN
      mem_ts[wr_ptr]   <= cyc;
`endif
    end
  end

  // Show-ahead read port, forced to zero while empty.
  assign rd_data = rd_valid ? mem_data[rd_ptr] : '0;
  assign rd_ovf  = rd_valid ? mem_ovf[rd_ptr]  : 1'b0;
`ifdef SOI_PROBE_TIMESTAMP_EN
  assign rd_ts   = rd_valid ? mem_ts[rd_ptr]   : '0;
`else
  assign rd_ts   = '0;
`endif

endmodule

// File: tb/tb_soi_probe.sv
// Testbench for soi_probe: directed stimulus, expected entries queued at
// stimulus time and checked by an independent monitor when the DUT pops them.
module tb_soi_probe;

  localparam int WIDTH = 1;
  localparam int DEPTH = 4;
  localparam int TS_W  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TS_W-1:0]  ts;
    logic             ovf;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] soi_in = '0;
  logic             arm = 1'b0;
  logic             rd_ready = 1'b0;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [TS_W-1:0]  rd_ts;
  logic             rd_ovf;
  logic [LW-1:0]    level;
  logic [15:0]      drop_cnt;

  entry_t          exp_q[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [TS_W-1:0] edge_cnt;   // rising edges since reset release, mod 2^TS_W

  soi_probe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .soi_in(soi_in), .arm(arm),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_ts(rd_ts), .rd_ovf(rd_ovf), .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= '0;
    else        edge_cnt <= edge_cnt + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the entry the DUT should produce at the next rising edge.
  task automatic push_exp(input logic [WIDTH-1:0] d, input logic [TS_W-1:0] ts, input logic o);
    entry_t e;
    e.data = d;
`ifdef SOI_PROBE_TIMESTAMP_EN
    e.ts = ts;
`else
    e.ts = ((ts & '0) == '0) ? '0 : '0;
`endif
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
  endtask

  // Monitor: on every accepted pop compare the head entry with the scoreboard;
  // while empty, the read outputs must be zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_without_expected_entry", 32'(exp_q.size()), 32'd1);
        end else begin
          entry_t e;
          e = exp_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e.data));
          check("rd_ts",   32'(rd_ts),   32'(e.ts));
          check("rd_ovf",  32'(rd_ovf),  32'(e.ovf));
        end
      end else if (!rd_valid) begin
        check("empty_outputs_zero", 32'({rd_data, rd_ts, rd_ovf}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, expected < 200000", $time);
    $fatal(1);
  end

  initial begin
    // Reset / idle: soi toggles under reset and while disarmed.
    for (int i = 0; i < 3; i++) begin
      tick();
      soi_in = ~soi_in;
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_level",    32'(level),    32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      soi_in = ~soi_in;
      tick();
      check("idle_level", 32'(level), 32'd0);
    end

    // Seed + one change.
    soi_in = 1'b1;
    arm    = 1'b1;
    tick();                              // arm sampled -> SEED
    push_exp(1'b1, edge_cnt, 1'b0);
    tick();                              // baseline written
    check("seed_level",    32'(level),    32'd1);
    check("seed_rd_valid", 32'(rd_valid), 32'd1);
    tick();
    tick();
    check("seed_hold_level", 32'(level), 32'd1);
    soi_in = 1'b0;
    push_exp(1'b0, edge_cnt, 1'b0);
    tick();
    check("change_level", 32'(level), 32'd2);
    drain(2);
    check("drained_level", 32'(level), 32'd0);

    // Overflow: re-arm, seed, then 8 changes with no reader.
    arm = 1'b0;
    tick();
    arm = 1'b1;
    tick();                              // SEED
    push_exp(soi_in, edge_cnt, 1'b0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      soi_in = ~soi_in;
      if (i <= 3) push_exp(soi_in, edge_cnt, 1'b0);
      tick();
    end
    check("ovf_level",    32'(level),    32'd4);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd5);
    drain(4);
    check("ovf_drained_level", 32'(level), 32'd0);
    soi_in = ~soi_in;
    push_exp(soi_in, edge_cnt, 1'b1);    // first entry after the drops
    tick();
    soi_in = ~soi_in;
    push_exp(soi_in, edge_cnt, 1'b0);    // flag cleared by the previous push
    tick();
    drain(2);
    check("ovf_drop_cnt_kept", 32'(drop_cnt), 32'd5);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      soi_in = ~soi_in;
      push_exp(soi_in, edge_cnt, 1'b0);
      tick();
    end
    check("full_level", 32'(level), 32'd4);
    soi_in   = ~soi_in;
    push_exp(soi_in, edge_cnt, 1'b0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("pushpop_level",    32'(level),    32'd4);
    check("pushpop_drop_cnt", 32'(drop_cnt), 32'd5);
    drain(4);
    check("pushpop_drained_level", 32'(level), 32'd0);

    // Timestamp wrap: changes at cyc=15 and cyc=0.
    for (int i = 0; i < 20 && edge_cnt != 4'd15; i++) tick();
    check("wrap_align", 32'(edge_cnt), 32'd15);
    soi_in = ~soi_in;
    push_exp(soi_in, 4'd15, 1'b0);
    tick();
    soi_in = ~soi_in;
    push_exp(soi_in, 4'd0, 1'b0);
    tick();
    drain(2);
    check("wrap_drop_cnt", 32'(drop_cnt), 32'd5);

    // Reset mid-stream with 3 entries queued.
    for (int i = 0; i < 3; i++) begin
      soi_in = ~soi_in;
      tick();
    end
    check("pre_reset_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("async_rst_level",    32'(level),    32'd0);
    check("async_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();                              // arm held 1 -> SEED
    push_exp(soi_in, edge_cnt, 1'b0);
    tick();
    check("post_rst_seed_level", 32'(level), 32'd1);
    tick();
    tick();
    check("post_rst_hold_level", 32'(level), 32'd1);
    drain(1);
    check("post_rst_drained_level", 32'(level), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
